// File: rtl/sorted_stream_sink.sv
// Receive endpoint for the sorter output stream: buffers one frame,
// checks key ordering, and reports length, checksum and overflow.
module sorted_stream_sink #(
  parameter int WIDTH_P    = 16,
  parameter int KEY_BITS_P = 10,
  parameter int N_MAX_P    = 256,
  parameter int ADDR_W_P   = $clog2(N_MAX_P),
  parameter int SUM_W_P    = WIDTH_P + ADDR_W_P + 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [WIDTH_P-1:0]  s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic                stall_en_i,
  input  logic                clear_i,
  input  logic [ADDR_W_P-1:0] rd_addr_i,
  output logic [WIDTH_P-1:0]  rd_data_o,
  output logic                done_o,
  output logic [ADDR_W_P:0]   len_o,
  output logic [SUM_W_P-1:0]  sum_o,
  output logic                order_err_o,
  output logic [ADDR_W_P:0]   err_idx_o,
  output logic                overflow_o
);

  localparam logic S_RECV = 1'b0;
  localparam logic S_DONE = 1'b1;
  localparam logic [ADDR_W_P:0] L_NMAX = (ADDR_W_P+1)'(N_MAX_P);

  logic                  r_state;
  logic [ADDR_W_P:0]     r_cnt;
  logic [SUM_W_P-1:0]    r_sum;
  logic                  r_oerr;
  logic [ADDR_W_P:0]     r_idx;
  logic                  r_ovf;
  logic [KEY_BITS_P-1:0] r_prev;
  logic [7:0]            r_lfsr;
  logic [WIDTH_P-1:0]    r_buf [N_MAX_P];

  logic                  w_hs;
  logic                  w_room;
  logic                  w_fb;
  logic [KEY_BITS_P-1:0] w_key;

  assign s_tready = (r_state == S_RECV) & ~clear_i
                  & ~(stall_en_i & r_lfsr[0]);
  assign w_hs   = s_tvalid & s_tready;
  assign w_room = r_cnt < L_NMAX;
  assign w_key  = s_tdata[KEY_BITS_P-1:0];
  assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Buffer is storage only; it is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_hs && w_room)
      r_buf[r_cnt[ADDR_W_P-1:0]] <= s_tdata;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_RECV;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_oerr  <= 1'b0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
      r_prev  <= '0;
      r_lfsr  <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
      if (clear_i) begin
        r_state <= S_RECV;
        r_cnt   <= '0;
        r_sum   <= '0;
        r_oerr  <= 1'b0;
        r_idx   <= '0;
        r_ovf   <= 1'b0;
        r_prev  <= '0;
      end else if (w_hs) begin
        if (w_room)
          r_cnt <= r_cnt + 1'b1;
        else
          r_ovf <= 1'b1;
        r_sum <= r_sum + SUM_W_P'(s_tdata);
        // Only the first violation's index is kept.
        if (r_cnt != '0 && w_key < r_prev && !r_oerr) begin
          r_oerr <= 1'b1;
          r_idx  <= r_cnt;
        end
        r_prev <= w_key;
        if (s_tlast)
          r_state <= S_DONE;
      end
    end
  end

  assign rd_data_o   = r_buf[rd_addr_i];
  assign done_o      = (r_state == S_DONE);
  assign len_o       = r_cnt;
  assign sum_o       = r_sum;
  assign order_err_o = r_oerr;
  assign err_idx_o   = r_idx;
  assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_sorted_stream_sink.sv
// Randomized scoreboard bench for sorted_stream_sink.
// Frame results come from a queue-based reference model.
module tb_sorted_stream_sink;
  localparam int W  = 16;
  localparam int N  = 256;
  localparam int AW = 8;
  localparam int SW = 25;

  typedef struct {
    int          len;
    logic [SW-1:0] sum;
    bit          oerr;
    int          idx;
    bit          ovf;
  } exp_t;

  logic          clk = 0;
  logic          rst = 1;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tvalid = 0;
  logic          s_tready;
  logic          s_tlast = 0;
  logic          stall = 0;
  logic          clear = 0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          done_o;
  logic [AW:0]   len_o;
  logic [SW-1:0] sum_o;
  logic          oerr_o;
  logic [AW:0]   idx_o;
  logic          ovf_o;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [W-1:0] mbuf[$];
  bit seen_done = 0;
  bit   m_recv;
  logic [7:0] m_lfsr;
  logic m_rdy;

  sorted_stream_sink dut (
    .clk_i(clk), .reset_i(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tlast(s_tlast),
    .stall_en_i(stall), .clear_i(clear),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .done_o(done_o), .len_o(len_o), .sum_o(sum_o),
    .order_err_o(oerr_o), .err_idx_o(idx_o),
    .overflow_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // x^8+x^6+x^5+x^4 feedback, shifted in at bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  assign m_rdy = m_recv & ~clear & ~(stall & m_lfsr[0]);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_recv = 1;
      m_lfsr = 8'hA5;
    end else begin
      if (clear) m_recv = 1;
      else if (s_tvalid && m_rdy && s_tlast) m_recv = 0;
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // Monitor: ready every cycle, frame status when done rises.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", 32'(s_tready), 32'(m_rdy));
      if (done_o && !seen_done) begin
        seen_done = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done_o), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("len", 32'(len_o), 32'(e.len));
          chk("sum", 32'(sum_o), 32'(e.sum));
          chk("order_err", 32'(oerr_o), 32'(e.oerr));
          chk("err_idx", 32'(idx_o), 32'(e.idx));
          chk("overflow", 32'(ovf_o), 32'(e.ovf));
        end
      end
      if (!done_o) seen_done = 0;
    end else begin
      seen_done = 0;
    end
  end

  function automatic exp_t model(input logic [W-1:0] d[$]);
    exp_t e;
    e.len  = d.size() > N ? N : d.size();
    e.sum  = '0;
    e.oerr = 0;
    e.idx  = 0;
    e.ovf  = d.size() > N;
    foreach (d[i]) e.sum = e.sum + SW'(d[i]);
    for (int i = 1; i < d.size(); i++) begin
      if (!e.oerr && d[i][9:0] < d[i-1][9:0]) begin
        e.oerr = 1;
        e.idx  = i > N ? N : i;
      end
    end
    return e;
  endfunction

  task automatic send(input logic [W-1:0] d[$], input bit last);
    int n;
    foreach (d[i]) begin
      s_tvalid = 1;
      s_tdata  = d[i];
      s_tlast  = last && (i == d.size() - 1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_tready && n < 2000);
      if (!s_tready) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: got no ready expected ready");
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 0;
    s_tlast  = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge clk);
    #1;
    clear = 0;
  endtask

  task automatic run(input logic [W-1:0] d[$]);
    int n;
    exp_q.push_back(model(d));
    mbuf.delete();
    foreach (d[i]) if (i < N) mbuf.push_back(d[i]);
    send(d, 1);
    n = 0;
    while (!done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 32'(done_o), 1);
    foreach (mbuf[i]) begin
      rd_addr = AW'(i);
      #1;
      chk("rd_data", 32'(rd_data), 32'(mbuf[i]));
    end
  endtask

  initial begin
    logic [W-1:0] d[$];
    logic [W-1:0] v;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_len", 32'(len_o), 0);
    chk("rst_sum", 32'(sum_o), 0);
    chk("rst_oerr", 32'(oerr_o), 0);
    chk("rst_idx", 32'(idx_o), 0);
    chk("rst_ovf", 32'(ovf_o), 0);
    @(posedge clk);
    #1;

    d = '{3, 5, 5, 9, 1023};
    run(d);
    chk("t1_len", 32'(len_o), 5);
    chk("t1_sum", 32'(sum_o), 1045);
    chk("t1_rd4", 32'(rd_data), 1023);
    do_clear();

    d = '{10, 20, 15, 30, 5};
    run(d);
    chk("t2_oerr", 32'(oerr_o), 1);
    chk("t2_idx", 32'(idx_o), 2);
    chk("t2_sum", 32'(sum_o), 80);
    do_clear();

    d.delete();
    for (int i = 0; i < N + 2; i++) d.push_back(W'($urandom));
    run(d);
    chk("t3_ovf", 32'(ovf_o), 1);
    chk("t3_len", 32'(len_o), N);
    do_clear();

    stall = 1;
    d.delete();
    for (int i = 0; i < 64; i++) d.push_back(W'(i));
    run(d);
    chk("t4_len", 32'(len_o), 64);
    do_clear();
    stall = 0;

    d = '{1, 2, 3};
    send(d, 0);
    s_tvalid = 1;
    s_tdata  = 99;
    do_clear();
    s_tvalid = 0;
    d = '{7};
    run(d);
    chk("t5_len", 32'(len_o), 1);
    chk("t5_sum", 32'(sum_o), 7);
    do_clear();

    d = '{16'h8001, 16'h0002};
    run(d);
    chk("t6_oerr", 32'(oerr_o), 0);
    do_clear();

    for (int f = 0; f < 8; f++) begin
      stall = 1'($urandom);
      d.delete();
      v = W'($urandom_range(0, 200));
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) begin
        if (f % 2 == 0) v = v + W'($urandom_range(0, 3));
        else v = W'($urandom);
        d.push_back(v);
      end
      run(d);
      do_clear();
    end
    stall = 0;

    d = '{16'h0050, 16'h0010};
    send(d, 0);
    @(negedge clk);
    chk("mid_oerr", 32'(oerr_o), 1);
    rst = 1;
    #2;
    chk("mrst_len", 32'(len_o), 0);
    chk("mrst_sum", 32'(sum_o), 0);
    chk("mrst_oerr", 32'(oerr_o), 0);
    chk("mrst_idx", 32'(idx_o), 0);
    chk("mrst_done", 32'(done_o), 0);
    chk("mrst_ovf", 32'(ovf_o), 0);
    @(posedge clk);
    #1;
    rst = 0;
    repeat (4) @(posedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
